instr_ram: RTL and testbench

INSTR_RAM -- requirements
Module: instr_ram

---
 rtl/instr_ram.sv | 119 +++++++++++
 tb/tb_instr_ram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_ram.sv
// Instruction RAM: init sweep of INIT_WORD over every word after reset, then fetch reads and loader writes.
// Read latency 1 cycle (registered dout); loader writes take effect at the accepting edge.
// load_ready is low for the whole init sweep and those loader writes are dropped; reads never stall in RUN.
// Optional per-word parity when the INSTR_RAM_PARITY_EN macro is defined.
module instr_ram #(
    parameter int              AW        = 12,
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   INIT_WORD = DW'(32'h00000013)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] instr_ram_addr,
    input  logic          instr_ram_rd,
    output logic [DW-1:0] instr_ram_dout,
    output logic          ready,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          parity_err
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [DW-1:0] mem [DEPTH];

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;

    // Loader is only accepted once the sweep has finished.
    assign load_ready = ready;

    // A read only happens outside reset and after the sweep.
    assign rd_en = !rst && instr_ram_rd && ready;

    // Single write port: the sweep owns it in INIT, the loader in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cnt;
        wr_data = INIT_WORD;
        if (!rst) begin
            if (state == S_INIT) begin
                wr_en = 1'b1;
            end else if (load_valid && load_ready) begin
                wr_en   = 1'b1;
                wr_addr = load_addr;
                wr_data = load_data;
            end
        end
    end

    // INIT/RUN sequencer; INIT lasts one cycle per word, RUN holds until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_RUN;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage write; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read data; read-first against a same-edge write, holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_ram_dout <= '0;
        end else if (rd_en) begin
            instr_ram_dout <= mem[instr_ram_addr];
        end
    end

`ifdef INSTR_RAM_PARITY_EN
    logic par_mem [DEPTH];

    // Parity bit stored alongside every write, sweep and loader alike.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_mem[wr_addr] <= ^wr_data;
        end
    end

    // Parity check follows dout exactly: updates on the same edges, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (rd_en) begin
            parity_err <= (par_mem[instr_ram_addr] != (^mem[instr_ram_addr]));
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_ram.sv
module tb_instr_ram;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] instr_ram_addr;
    logic          instr_ram_rd;
    logic [DW-1:0] instr_ram_dout;
    logic          ready;
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          parity_err;

    instr_ram #(.AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .instr_ram_addr (instr_ram_addr),
        .instr_ram_rd   (instr_ram_rd),
        .instr_ram_dout (instr_ram_dout),
        .ready          (ready),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .parity_err     (parity_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: plain array of word contents plus the last read result.
    logic [31:0] model [DEPTH];
    logic [31:0] exp_dout;

    typedef struct {
        logic        lv;
        logic [3:0]  la;
        logic [31:0] ld;
        logic        rd;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge, then outputs are stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_ram_rd = 1'b0;
        instr_ram_addr = '0;
        load_valid = 1'b0;
        load_addr = '0;
        load_data = '0;
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    endtask

    // Count edges after reset release until ready rises (bounded).
    task automatic wait_ready(input string name, output int edges);
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready) begin
                edges = i;
                break;
            end
        end
        check(name, edges, 16);
    endtask

    task automatic do_read(input string name, input logic [3:0] a, input logic [31:0] exp);
        instr_ram_rd = 1'b1;
        instr_ram_addr = a;
        tick();
        instr_ram_rd = 1'b0;
        check(name, instr_ram_dout, exp);
    endtask

    initial begin
        vec_t vecs[10];
        int   edges;

        vecs[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 4'd0,  NOP};
        vecs[1] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd3,  32'hDEADBEEF};
        vecs[2] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd3,  32'hDEADBEEF};
        vecs[3] = '{1'b1, 4'd7,  32'h12345678, 1'b1, 4'd7,  NOP};
        vecs[4] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd7,  32'h12345678};
        vecs[5] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd2,  NOP};
        vecs[6] = '{1'b1, 4'd15, 32'hA5A5A5A5, 1'b1, 4'd3,  32'hDEADBEEF};
        vecs[7] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd15, 32'hA5A5A5A5};
        vecs[8] = '{1'b1, 4'd0,  32'h00000000, 1'b1, 4'd0,  NOP};
        vecs[9] = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd0,  32'h00000000};

        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("reset_dout", instr_ram_dout, 32'h0);
        check("reset_ready", {31'b0, ready}, 32'h0);
        check("reset_load_ready", {31'b0, load_ready}, 32'h0);
        check("reset_parity", {31'b0, parity_err}, 32'h0);

        // First sweep, with a loader write attempted at cnt=4.
        rst = 1'b0;
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 4) begin
                load_valid = 1'b1;
                load_addr = 4'd2;
                load_data = 32'hFFFFFFFF;
                #1;
                check("init_load_ready", {31'b0, load_ready}, 32'h0);
            end else begin
                load_valid = 1'b0;
            end
            if (ready) begin
                edges = i;
                break;
            end
        end
        check("sweep_len", edges, 16);
        check("run_load_ready", {31'b0, load_ready}, 32'h1);
        model_init();
        do_read("nop_addr5", 4'd5, NOP);
        check("nop_parity", {31'b0, parity_err}, 32'h0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            load_valid = vecs[i].lv;
            load_addr = vecs[i].la;
            load_data = vecs[i].ld;
            instr_ram_rd = vecs[i].rd;
            instr_ram_addr = vecs[i].ra;
            tick();
            if (vecs[i].lv) model[vecs[i].la] = vecs[i].ld;
            check($sformatf("vec%0d", i), instr_ram_dout, vecs[i].exp);
        end
        idle_inputs();
        exp_dout = vecs[9].exp;

        // Randomized traffic against the array model.
        for (int i = 0; i < 300; i++) begin
            logic       lv, rd;
            logic [3:0] la, ra;
            logic [31:0] ld;
            lv = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            la = 4'($urandom_range(0, 15));
            ra = (i % 5 == 0) ? la : 4'($urandom_range(0, 15));
            ld = $urandom;
            load_valid = lv;
            load_addr = la;
            load_data = ld;
            instr_ram_rd = rd;
            instr_ram_addr = ra;
            tick();
            if (rd) exp_dout = model[ra];
            if (lv) model[la] = ld;
            check($sformatf("rand%0d", i), instr_ram_dout, exp_dout);
            check($sformatf("rand_par%0d", i), {31'b0, parity_err}, 32'h0);
        end
        idle_inputs();

        // Reset from RUN, then a one-cycle reset again at cnt=9.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst9_ready", {31'b0, ready}, 32'h0);
        check("rst9_dout", instr_ram_dout, 32'h0);
        wait_ready("resweep_len", edges);
        model_init();
        do_read("reinit_addr3", 4'd3, NOP);
        do_read("reinit_addr7", 4'd7, NOP);

`ifdef INSTR_RAM_PARITY_EN
        dut.mem[1] = dut.mem[1] ^ 32'h00000001;
        do_read("flip_addr1", 4'd1, NOP ^ 32'h1);
        check("flip_parity", {31'b0, parity_err}, 32'h1);
        do_read("clean_addr0", 4'd0, NOP);
        check("clean_parity", {31'b0, parity_err}, 32'h0);
`else
        do_read("addr1", 4'd1, NOP);
        check("noparity_1", {31'b0, parity_err}, 32'h0);
        do_read("addr0", 4'd0, NOP);
        check("noparity_0", {31'b0, parity_err}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
